// File: rtl/cnt_date.sv
// Calendar day/month counter: auto-advances on pulse_1d in run mode, manual adjust in set mode.
// Optional leap-year February (29 days when year_in[1:0]==0) via `define CNT_DATE_LEAP_YEAR_EN.
module cnt_date #(
  parameter logic [4:0] DAY_RST   = 5'd1,
  parameter logic [3:0] MONTH_RST = 4'd1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pulse_1d,
  input  logic       enable_cnt_date,
  input  logic       increase_d,
  input  logic       decrease_d,
  input  logic       increase_m,
  input  logic       decrease_m,
  input  logic [6:0] year_in,
  output logic [4:0] cnt_day,
  output logic [3:0] cnt_month,
  output logic       pulse_1y
);

  logic [4:0] day_reg, day_next;
  logic [3:0] month_reg, month_next;
  logic [3:0] month_adj;
  logic [4:0] cur_len, new_len;
  logic       leap;
  logic       state_ok;

  function automatic logic [4:0] month_len(input logic [3:0] m, input logic lp);
    case (m)
      4'd2:                    month_len = lp ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11: month_len = 5'd30;
      default:                 month_len = 5'd31;
    endcase
  endfunction

`ifdef CNT_DATE_LEAP_YEAR_EN
  assign leap = (year_in[1:0] == 2'b00);
`else
  logic unused_year;
  assign unused_year = ^year_in;
  assign leap        = 1'b0;
`endif

  // Month after a manual month step (only consumed when neither day strobe wins)
  always_comb begin
    month_adj = month_reg;
    if (increase_m)
      month_adj = (month_reg == 4'd12) ? 4'd1 : month_reg + 4'd1;
    else if (decrease_m)
      month_adj = (month_reg == 4'd1) ? 4'd12 : month_reg - 4'd1;
  end

  assign cur_len  = month_len(month_reg, leap);
  assign new_len  = month_len(month_adj, leap);
  assign state_ok = (month_reg >= 4'd1) && (month_reg <= 4'd12) && (day_reg != 5'd0);

  always_comb begin
    day_next   = day_reg;
    month_next = month_reg;
    if (!state_ok) begin
      day_next   = DAY_RST;
      month_next = MONTH_RST;
    end else if (day_reg > cur_len) begin
      // Year change shortened February under us; clamp and do nothing else
      day_next = cur_len;
    end else if (enable_cnt_date) begin
      if (pulse_1d) begin
        if (day_reg < cur_len) begin
          day_next = day_reg + 5'd1;
        end else begin
          day_next   = 5'd1;
          month_next = (month_reg == 4'd12) ? 4'd1 : month_reg + 4'd1;
        end
      end
    end else if (increase_d) begin
      day_next = (day_reg == cur_len) ? 5'd1 : day_reg + 5'd1;
    end else if (decrease_d) begin
      day_next = (day_reg == 5'd1) ? cur_len : day_reg - 5'd1;
    end else if (increase_m || decrease_m) begin
      month_next = month_adj;
      day_next   = (day_reg > new_len) ? new_len : day_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      day_reg   <= DAY_RST;
      month_reg <= MONTH_RST;
    end else begin
      day_reg   <= day_next;
      month_reg <= month_next;
    end
  end

  assign cnt_day   = day_reg;
  assign cnt_month = month_reg;
  assign pulse_1y  = ~rst & pulse_1d & enable_cnt_date &
                     (day_reg == 5'd31) & (month_reg == 4'd12);

endmodule

// File: tb/tb_cnt_date.sv
// Self-checking bench for cnt_date: directed vector table, async reset sequence, random run vs calendar model.
module tb_cnt_date;

`ifdef CNT_DATE_LEAP_YEAR_EN
  localparam bit LEAP = 1'b1;
`else
  localparam bit LEAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pulse_1d = 1'b0;
  logic       enable_cnt_date = 1'b0;
  logic       increase_d = 1'b0;
  logic       decrease_d = 1'b0;
  logic       increase_m = 1'b0;
  logic       decrease_m = 1'b0;
  logic [6:0] year_in = 7'd23;
  logic [4:0] cnt_day;
  logic [3:0] cnt_month;
  logic       pulse_1y;

  always #5 clk = ~clk;

  cnt_date dut (
    .clk(clk), .rst(rst), .pulse_1d(pulse_1d), .enable_cnt_date(enable_cnt_date),
    .increase_d(increase_d), .decrease_d(decrease_d),
    .increase_m(increase_m), .decrease_m(decrease_m),
    .year_in(year_in), .cnt_day(cnt_day), .cnt_month(cnt_month), .pulse_1y(pulse_1y)
  );

  typedef struct {
    bit en, p1d, id, dd, im, dm;
    int yr;
    int ed, em, ep;
  } vec_t;

  vec_t tbl[$];
  int   m_day, m_month;
  int   n_checks = 0;
  int   n_err = 0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Calendar lengths from the month table, February stretched in leap years
  function automatic int mlen(input int m, input int y);
    int dim[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    int l;
    l = dim[m-1];
    if (LEAP && m == 2 && (y % 4) == 0) l = 29;
    return l;
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_step(input vec_t v);
    int l;
    l = mlen(m_month, v.yr);
    if (m_day > l) begin
      m_day = l;
    end else if (v.en) begin
      if (v.p1d) begin
        m_day++;
        if (m_day > l) begin
          m_day   = 1;
          m_month = (m_month % 12) + 1;
        end
      end
    end else if (v.id) begin
      m_day = (m_day % l) + 1;
    end else if (v.dd) begin
      m_day = (m_day == 1) ? l : m_day - 1;
    end else if (v.im) begin
      m_month = (m_month % 12) + 1;
      m_day   = min2(m_day, mlen(m_month, v.yr));
    end else if (v.dm) begin
      m_month = ((m_month + 10) % 12) + 1;
      m_day   = min2(m_day, mlen(m_month, v.yr));
    end
  endtask

  // One clock cycle: drive, check the combinational carry mid-cycle, check registers after the edge
  task automatic apply(input vec_t v, output int got_p1y);
    int exp_p1y;
    enable_cnt_date = v.en; pulse_1d = v.p1d;
    increase_d = v.id; decrease_d = v.dd; increase_m = v.im; decrease_m = v.dm;
    year_in = 7'(v.yr);
    @(negedge clk);
    exp_p1y = (v.en && v.p1d && m_day == 31 && m_month == 12) ? 1 : 0;
    got_p1y = int'(pulse_1y);
    check("model_pulse_1y", got_p1y, exp_p1y);
    @(posedge clk);
    #1;
    model_step(v);
    check("model_day", int'(cnt_day), m_day);
    check("model_month", int'(cnt_month), m_month);
  endtask

  task automatic push(input bit en, p1d, id, dd, im, dm, input int yr, ed, em, ep);
    vec_t v;
    v.en = en; v.p1d = p1d; v.id = id; v.dd = dd; v.im = im; v.dm = dm;
    v.yr = yr; v.ed = ed; v.em = em; v.ep = ep;
    tbl.push_back(v);
  endtask

  initial begin
    vec_t v;
    int   p1y;
    int   yr;

    // Directed table, starting from 1 Jan after reset
    push(0,0,0,0,0,1, 23,  1,12,0);  // 1 Jan -> 1 Dec
    push(0,0,0,1,0,0, 23, 31,12,0);  // -> 31 Dec
    push(1,1,0,0,0,0, 23,  1, 1,1);  // year carry, wrap to 1 Jan
    push(1,1,1,0,0,0, 23,  2, 1,0);  // manual strobes ignored in run
    push(1,0,0,0,1,0, 23,  2, 1,0);
    push(0,1,0,0,0,0, 23,  2, 1,0);  // pulse ignored in set
    push(0,0,1,0,0,1, 23,  3, 1,0);  // increase_d beats decrease_m
    push(0,0,0,1,1,0, 23,  2, 1,0);  // decrease_d beats increase_m
    push(0,0,0,0,1,1, 23,  2, 2,0);  // increase_m beats decrease_m
    push(0,0,0,1,0,0, 23,  1, 2,0);
    push(0,0,0,1,0,0, 23, 28, 2,0);  // 1 Feb back to 28 Feb
    push(0,0,1,0,0,0, 23,  1, 2,0);
    push(0,0,0,1,0,0, 23, 28, 2,0);
    push(1,1,0,0,0,0, 23,  1, 3,0);  // 28 Feb non-leap -> 1 Mar
    push(0,0,0,1,0,0, 23, 31, 3,0);
    push(0,0,0,0,1,0, 23, 30, 4,0);  // 31 Mar -> 30 Apr
    push(0,0,1,0,0,0, 23,  1, 4,0);
    push(0,0,0,1,0,0, 23, 30, 4,0);  // 1 Apr -> 30 Apr
    push(0,0,0,0,1,0, 23, 30, 5,0);
    push(0,0,0,0,1,0, 23, 30, 6,0);
    push(0,0,1,0,0,0, 23,  1, 6,0);
    for (int d = 2; d <= 5; d++) push(0,0,1,0,0,0, 23, d, 6,0);
    push(0,0,1,0,0,1, 23,  6, 6,0);  // 5 Jun, both strobes -> 6 Jun
    for (int m = 5; m >= 2; m--) push(0,0,0,0,0,1, 23, 6, m,0);
    for (int d = 5; d >= 1; d--) push(0,0,0,1,0,0, 23, d, 2,0);
    push(0,0,0,1,0,0, 23, 28, 2,0);
    push(1,1,0,0,0,0, 24, LEAP ? 29 : 1, LEAP ? 2 : 3, 0);  // leap-year Feb
    push(0,0,0,0,0,0, 25, LEAP ? 28 : 1, LEAP ? 2 : 3, 0);  // year change clamps 29 Feb
    push(1,1,0,0,0,0, 25, LEAP ? 1 : 2, 3, 0);

    // Asynchronous reset, checked before any clock edge
    #1 rst = 1'b1;
    #2;
    check("rst_async_day", int'(cnt_day), 1);
    check("rst_async_month", int'(cnt_month), 1);
    check("rst_pulse_1y", int'(pulse_1y), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_day = 1; m_month = 1;
    $display("reset released: day=%0d month=%0d", cnt_day, cnt_month);

    foreach (tbl[i]) begin
      v = tbl[i];
      apply(v, p1y);
      $display("vec %0d: en=%0d p1d=%0d id=%0d dd=%0d im=%0d dm=%0d yr=%0d -> day=%0d month=%0d p1y=%0d",
               i, v.en, v.p1d, v.id, v.dd, v.im, v.dm, v.yr, cnt_day, cnt_month, p1y);
      check("tbl_day", int'(cnt_day), v.ed);
      check("tbl_month", int'(cnt_month), v.em);
      check("tbl_pulse_1y", p1y, v.ep);
    end

    // Reset mid-count with a pending strobe; the strobe is lost, the first edge after release counts
    enable_cnt_date = 1'b1; pulse_1d = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_day", int'(cnt_day), 1);
    check("midrst_month", int'(cnt_month), 1);
    check("midrst_pulse_1y", int'(pulse_1y), 0);
    enable_cnt_date = 1'b0; pulse_1d = 1'b0; increase_d = 1'b1;
    @(posedge clk); #1;
    check("rst_holds_day", int'(cnt_day), 1);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    check("first_edge_day", int'(cnt_day), 2);
    check("first_edge_month", int'(cnt_month), 1);
    $display("reset sequence: day=%0d month=%0d", cnt_day, cnt_month);
    increase_d = 1'b0;
    m_day = 2; m_month = 1;

    // Random traffic against the calendar model
    yr = 24;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 15) == 0) yr = $urandom_range(0, 99);
      v.en  = ($urandom_range(0, 1) == 1);
      v.p1d = ($urandom_range(0, 1) == 1);
      v.id  = ($urandom_range(0, 3) == 0);
      v.dd  = ($urandom_range(0, 3) == 0);
      v.im  = ($urandom_range(0, 3) == 0);
      v.dm  = ($urandom_range(0, 3) == 0);
      v.yr  = yr;
      v.ed = 0; v.em = 0; v.ep = 0;
      apply(v, p1y);
      $display("rnd %0d: en=%0d p1d=%0d id=%0d dd=%0d im=%0d dm=%0d yr=%0d -> day=%0d month=%0d p1y=%0d",
               n, v.en, v.p1d, v.id, v.dd, v.im, v.dm, v.yr, cnt_day, cnt_month, p1y);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
